// File: rtl/sevenseg_pkg.sv
// Shared state encoding and glyph helpers for the multiplexed seven-segment controller.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle, DATA_W iterations.
// done_o is high during the cycle that performs the final iteration.
module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     value_i,
  output logic                  done_o,
  output logic [4*DIGITS+3:0]   bcd_o
);

  localparam int BCD_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;

  assign done_o = run_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign bcd_o  = bcd_q;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS + 1; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      sh_d  = value_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj[BCD_W-2:0], sh_q[DATA_W-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/sevenseg_mux_ctrl.sv
// Multiplexed common-anode seven-segment controller with hex/decimal display and atomic update.
// States: IDLE watches value/mode | SHIFT runs the BCD converter | LOAD commits the display register.
module sevenseg_mux_ctrl
  import sevenseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              blank_lz,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] AN
);

  localparam int BCD_W   = 4*DIGITS + 4;
  localparam int DISP_W  = 4*DIGITS;
  localparam int EXT_W   = (DATA_W > DISP_W) ? DATA_W : DISP_W;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRESC_W = $clog2(REFRESH_DIV);

  conv_state_e        state_q, state_d;
  logic [DATA_W-1:0]  val_q, val_d;
  logic               mode_q, mode_d;
  logic [DISP_W-1:0]  disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  an_q, an_d;

  logic               conv_start;
  logic               conv_done;
  logic [BCD_W-1:0]   bcd;
  logic [EXT_W-1:0]   val_ext;
  logic [DIGITS-1:0]  upper_zero;
  logic               zacc;
  logic [3:0]         digit_nib;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .value_i (value),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  assign val_ext = EXT_W'(val_q);
  assign busy    = (state_q == ST_SHIFT);
  assign SEG     = seg_q;
  assign AN      = an_q;

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    mode_d     = mode_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    conv_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if ((value != val_q) || (mode != mode_q)) begin
          val_d      = value;
          mode_d     = mode;
          conv_start = mode;
          state_d    = mode ? ST_SHIFT : ST_LOAD;
        end
      end
      ST_SHIFT: begin
        if (conv_done) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (mode_q) begin
          disp_d = bcd[DISP_W-1:0];
          ovf_d  = |bcd[BCD_W-1:DISP_W];
        end else begin
          disp_d = val_ext[DISP_W-1:0];
          ovf_d  = |(val_ext >> DISP_W);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // upper_zero[k]: digit k and every digit above it are zero (leading-zero run).
  always_comb begin
    zacc       = 1'b1;
    upper_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zacc          = zacc && (disp_q[4*k +: 4] == 4'd0);
      upper_zero[k] = zacc;
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    digit_nib = disp_q[{idx_q, 2'b00} +: 4];
    if (ovf_q)                                           seg_d = SEG_DASH;
    else if (blank_lz && (idx_q != '0) && upper_zero[idx_q]) seg_d = SEG_BLANK;
    else                                                 seg_d = hex_to_seg(digit_nib);
    an_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      mode_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_ctrl.sv
// Scoreboarded bench for sevenseg_mux_ctrl: expected scan frames are queued by the stimulus
// and compared by a monitor that captures one full 4-digit frame per queued entry.
module tb_sevenseg_mux_ctrl;

  localparam int DIGITS      = 4;
  localparam int DATA_W      = 16;
  localparam int REFRESH_DIV = 4;

  typedef logic [DIGITS-1:0][6:0] frame_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mode = 1'b1;
  logic              blank_lz = 1'b1;
  logic [DATA_W-1:0] value = '0;
  logic              busy;
  logic [6:0]        SEG;
  logic [DIGITS-1:0] AN;

  int checks = 0;
  int errors = 0;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  sevenseg_mux_ctrl #(
    .DIGITS      (DIGITS),
    .DATA_W      (DATA_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .blank_lz (blank_lz),
    .value    (value),
    .busy     (busy),
    .SEG      (SEG),
    .AN       (AN)
  );

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Display contents from plain arithmetic: digit k = (v / radix^k) mod radix.
  function automatic frame_t model(input int v, input bit dec, input bit blz);
    int d[DIGITS];
    int radix;
    int div;
    int top;
    bit ovf;
    frame_t f;
    radix = dec ? 10 : 16;
    div = 1;
    top = -1;
    for (int k = 0; k < DIGITS; k++) begin
      d[k] = (v / div) % radix;
      div  = div * radix;
      if (d[k] != 0) top = k;
    end
    ovf = (v >= div);
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf)                            f[k] = 7'b0111111;
      else if (blz && k > top && k != 0)  f[k] = 7'h7F;
      else                                f[k] = glyph(d[k]);
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic wait_digit0();
    logic [DIGITS-1:0] prev;
    bit found;
    prev  = AN;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (AN == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = AN;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL digit0_sync: AN=%b, expected a new 1110 window within 64 cycles", AN);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_timeout: %0d frames pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic expect_frame(input int v, input bit dec, input bit blz);
    exp_q.push_back(model(v, dec, blz));
    drain();
  endtask

  // Monitor: arms on the start of a digit-0 window while an expectation is queued,
  // records 4*REFRESH_DIV cycles and compares each digit slot.
  initial begin : monitor
    logic [DIGITS-1:0] prev_an;
    logic [DIGITS-1:0] an_log [DIGITS*REFRESH_DIV];
    logic [6:0]        seg_log[DIGITS*REFRESH_DIV];
    logic [DIGITS-1:0] exp_an;
    frame_t            cur_exp;
    int                col;
    int                bad;
    prev_an = '1;
    col     = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        col = -1;
      end else begin
        if (col < 0 && exp_q.size() > 0 && AN == 4'b1110 && prev_an != 4'b1110) begin
          cur_exp = exp_q[0];
          col     = 0;
        end
        if (col >= 0) begin
          an_log[col]  = AN;
          seg_log[col] = SEG;
          col++;
          if (col == DIGITS*REFRESH_DIV) begin
            for (int d = 0; d < DIGITS; d++) begin
              exp_an = ~(4'b0001 << d);
              bad    = -1;
              for (int c = 0; c < REFRESH_DIV; c++) begin
                if (bad < 0 && (an_log[d*REFRESH_DIV+c] !== exp_an ||
                                seg_log[d*REFRESH_DIV+c] !== cur_exp[d]))
                  bad = d*REFRESH_DIV + c;
              end
              checks++;
              if (bad >= 0) begin
                errors++;
                $display("FAIL frame_digit%0d: AN=%b SEG=%b, expected AN=%b SEG=%b",
                         d, an_log[bad], seg_log[bad], exp_an, cur_exp[d]);
              end
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            col = -1;
          end
        end
      end
      prev_an = AN;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int busy_cnt;
    int sel;
    int v;

    // Reset state and first cycle after release.
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(SEG), 32'h7F);
    check("reset_an", 32'(AN), 32'hF);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_an", 32'(AN), 32'hE);
    check("first_seg", 32'(SEG), 32'h40);
    expect_frame(0, 1'b1, 1'b1);

    // Decimal latency and busy length: 0 -> 1234.
    wait_digit0();
    value = 16'd1234;
    busy_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i == 0) check("busy_rise", 32'(busy), 32'd1);
    end
    check("busy_len", 32'(busy_cnt), 32'd16);
    check("dec_seg_before_load", 32'(SEG), 32'h40);
    @(negedge clk);
    check("dec_an_after_load", 32'(AN), 32'hE);
    check("dec_seg_after_load", 32'(SEG), 32'h19);
    expect_frame(1234, 1'b1, 1'b1);

    // Hex latency: 1234 (decimal) -> 0xBEEF (hex).
    wait_digit0();
    mode  = 1'b0;
    value = 16'hBEEF;
    repeat (2) @(negedge clk);
    check("hex_seg_before_load", 32'(SEG), 32'h19);
    @(negedge clk);
    check("hex_seg_after_load", 32'(SEG), 32'h0E);
    check("hex_busy", 32'(busy), 32'd0);
    expect_frame(16'hBEEF, 1'b0, 1'b1);

    // Decimal overflow.
    mode  = 1'b1;
    value = 16'd10000;
    repeat (24) @(negedge clk);
    expect_frame(10000, 1'b1, 1'b1);

    // Value changes mid-SHIFT: 1234 completes first, 42 follows.
    wait_digit0();
    value = 16'd1234;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 4) value = 16'd42;
    end
    check("midshift_seg_old", 32'(SEG), 32'h3F);
    @(negedge clk);
    check("midshift_first_load", 32'(SEG), 32'h19);
    check("midshift_reconvert", 32'(busy), 32'd1);
    repeat (24) @(negedge clk);
    expect_frame(42, 1'b1, 1'b1);

    // Asynchronous reset during SHIFT.
    value = 16'd9999;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", 32'(SEG), 32'h7F);
    check("async_rst_an", 32'(AN), 32'hF);
    check("async_rst_busy", 32'(busy), 32'd0);
    value = '0;
    mode  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerelease_an", 32'(AN), 32'hE);
    check("rerelease_seg", 32'(SEG), 32'h40);
    expect_frame(0, 1'b0, 1'b1);

    // Randomized values, radix and blanking.
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = $urandom_range(0, 65535);
        1:       v = $urandom_range(0, 99);
        2:       v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 4095);
      endcase
      value    = 16'(v);
      mode     = 1'($urandom_range(0, 1));
      blank_lz = 1'($urandom_range(0, 1));
      repeat (24) @(negedge clk);
      expect_frame(v, mode, blank_lz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_mux_ctrl.md
# sevenseg_mux_ctrl

Parametrised multiplexed seven-segment display controller, successor to the fixed 4-digit controller. Accepts a binary value and a radix-mode input, converts sequentially to BCD (decimal mode) or splits nibbles (hex mode), and drives time-multiplexed common-anode digits. Sits between the motor-status datapath and the board's `SEG`/`AN` pins. Adds leading-zero blanking, overflow indication, and tear-free atomic display update.

## Interface
- `DIGITS`, 4: number of digits driven.
- `DATA_W`, 16: width of `value`.
- `REFRESH_DIV`, 100000: clock cycles each digit is enabled; must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `mode`  in  1  0 = hexadecimal, 1 = decimal.
- `blank_lz`  in  1  1 = blank leading zero digits.
- `value`  in  DATA_W  unsigned number to display.
- `busy`  out  1  high while a decimal conversion is in progress.
- `SEG`  out  7  active-low segments `{g,f,e,d,c,b,a}`; glyph "0" = 7'b1000000.
- `AN`  out  DIGITS  active-low digit enables; exactly one low outside reset.

## Operation
- Converter FSM: `IDLE`, `SHIFT`, `LOAD`.
- `IDLE`: compare `value`/`mode` against the captured copies. On mismatch, capture both. Captured `mode` = 1 → `SHIFT` with counter 0; `mode` = 0 → `LOAD`.
- `SHIFT`: one double-dabble iteration per cycle. Add 3 to every BCD nibble ≥ 5, then shift left one bit, taking the next captured-value MSB. Runs exactly DATA_W cycles, then goes to `LOAD`.
- BCD scratch width is 4·DIGITS + 4 bits. Any nonzero nibble above digit DIGITS-1 marks overflow.
- Hex path: digit k = captured value bits [4k+3:4k]. Overflow if any captured bit at index ≥ 4·DIGITS.
- `LOAD`: write all digits plus overflow flag into the display register in one cycle, then go to `IDLE`.
- The display register changes only in `LOAD`; the scan logic never shows a partial result.
- Changes to `value`/`mode` during `SHIFT`/`LOAD` are ignored. They are caught by the `IDLE` compare afterwards.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1.
  - On terminal count, the digit index increments, wrapping DIGITS-1 → 0.
  - `AN` = ~(1 << index).
- Glyph selection for digit at index:
  - Overflow set: segment g only (`SEG` = 7'b0111111) on all digits.
  - Else if `blank_lz` = 1, the index is above the highest nonzero digit, and index ≠ 0: `SEG` = 7'h7F.
  - Else: hex glyph 0–F.
- Digit 0 is never blanked, so value 0 shows "0".

## Timing
- Reset values: `SEG` = 7'h7F, `AN` = all ones, `busy` = 0. Prescaler, index, display register, captured value/mode and FSM state are all cleared (`IDLE`, value 0, mode 0).
- Reset mid-conversion aborts; the display reverts to 0.
- `SEG` and `AN` are registered from the index, display register, and `blank_lz`.
  - First cycle after reset release: `AN` = ...1110 with digit-0 glyph.
- Latency from a `value` change (sampled in `IDLE`) to display register update:
  - Decimal: DATA_W + 2 cycles.
  - Hex: 2 cycles.
  - Outputs follow one cycle later.
- `busy` is high exactly during the DATA_W `SHIFT` cycles.
- Each digit is held exactly REFRESH_DIV cycles; the full frame is DIGITS·REFRESH_DIV cycles.
- A `mode` toggle alone triggers reconversion.

## Structure
- Package `sevenseg_pkg`:
  - FSM state enum.
  - Glyph constants: blank, dash.
  - Function `hex_to_seg(4-bit) → 7-bit`.
- Sub-module `bin2bcd_seq`: sequential double-dabble with `start`/`done`, parametrised on DATA_W and DIGITS. The top instantiates it and owns capture, overflow, display register, and scan.

## Test plan
Use REFRESH_DIV = 4, DIGITS = 4, DATA_W = 16.
- Reset, `value` = 0, `mode` = 1, `blank_lz` = 1 → `AN` cycles 1110/1101/1011/0111 every 4 clocks. Digit 0 `SEG` = 7'b1000000; digits 1–3 `SEG` = 7'h7F.
- `mode` = 1, `value` = 1234 → `busy` high for 16 cycles; display register = 1,2,3,4 at cycle 18. Digit 0 `SEG` = 7'b0011001 ("4").
- `mode` = 0, `value` = 16'hBEEF → digits F,E,E,B after 2 cycles. Digit 3 `SEG` = 7'b0000011 ("b").
- `mode` = 1, `value` = 10000 → overflow; all digits `SEG` = 7'b0111111.
- `value` changed from 1234 to 42 during `SHIFT` → 1234 is loaded first, then 42 follows DATA_W + 2 cycles after `IDLE`. No mixed digits are ever visible.
- `rst` asserted mid-`SHIFT` → `SEG` = 7'h7F, `AN` = 4'hF, `busy` = 0 immediately (asynchronous). After release, display shows 0.
